// File: rtl/mem_responder.sv
// mem_responder: single-outstanding memory responder with a word-addressed,
// byte-enabled storage array and a fixed, parameterised response latency.
//
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_req_valid/o_req_ready request handshake (ready only while idle)
//   i_req_we                1 = write, 0 = read
//   i_req_addr              word address (ADDR_W bits, fully decoded)
//   i_req_wdata, i_req_be   write data and per-byte enables
//   o_rsp_valid/i_rsp_ready response handshake
//   o_rsp_rdata             read data (0 for writes and out-of-range accesses)
//   o_rsp_err               set when the address is beyond the stored words
module mem_responder #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 32,
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_STATES = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_req_we,
    input  logic [ADDR_W-1:0]     i_req_addr,
    input  logic [DATA_W-1:0]     i_req_wdata,
    input  logic [DATA_W/8-1:0]   i_req_be,
    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic [DATA_W-1:0]     o_rsp_rdata,
    output logic                  o_rsp_err
);

    localparam int BE_W  = DATA_W / 8;
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int WS_M1 = (WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0;
    localparam logic [3:0] WS_LOAD = WS_M1[3:0];

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Any set bit above the storage index range makes the address invalid,
    // so high address bits never alias onto stored words.
    function automatic logic in_range_f(input logic [ADDR_W-1:0] addr);
        return ((addr >> DEPTH_LOG2) == {ADDR_W{1'b0}});
    endfunction

    logic [DATA_W-1:0]     mem_r [DEPTH];

    state_t                state_r;
    state_t                next_state_s;
    logic [3:0]            cnt_r;
    logic [3:0]            cnt_next_s;
    logic                  ready_r;
    logic                  rsp_valid_r;
    logic [DATA_W-1:0]     rdata_r;
    logic                  err_r;

    logic                  cap_we_r;
    logic [ADDR_W-1:0]     cap_addr_r;
    logic [DATA_W-1:0]     cap_wdata_r;
    logic [BE_W-1:0]       cap_be_r;

    logic                  accept_s;
    logic                  access_s;
    logic                  acc_we_s;
    logic [ADDR_W-1:0]     acc_addr_s;
    logic [DATA_W-1:0]     acc_wdata_s;
    logic [BE_W-1:0]       acc_be_s;
    logic                  acc_in_range_s;
    logic [DEPTH_LOG2-1:0] acc_idx_s;
    logic                  mem_we_s;

    assign accept_s       = ready_r & i_req_valid;
    assign acc_in_range_s = in_range_f(acc_addr_s);
    assign acc_idx_s      = acc_addr_s[DEPTH_LOG2-1:0];
    // Storage is never touched while reset is held, even if a request is presented.
    assign mem_we_s       = access_s & acc_we_s & acc_in_range_s & i_rst_n;

    assign o_req_ready = ready_r;
    assign o_rsp_valid = rsp_valid_r;
    assign o_rsp_rdata = rdata_r;
    assign o_rsp_err   = err_r;

    // Next-state, wait counter and access-strobe decode.
    always_comb begin
        next_state_s = state_r;
        cnt_next_s   = cnt_r;
        access_s     = 1'b0;
        acc_we_s     = cap_we_r;
        acc_addr_s   = cap_addr_r;
        acc_wdata_s  = cap_wdata_r;
        acc_be_s     = cap_be_r;
        case (state_r)
            ST_IDLE: begin
                if (i_req_valid) begin
                    if (WAIT_STATES == 0) begin
                        // Zero-wait access uses the request bus directly because
                        // the capture registers load on this same edge.
                        access_s     = 1'b1;
                        acc_we_s     = i_req_we;
                        acc_addr_s   = i_req_addr;
                        acc_wdata_s  = i_req_wdata;
                        acc_be_s     = i_req_be;
                        next_state_s = ST_RESP;
                    end else begin
                        cnt_next_s   = WS_LOAD;
                        next_state_s = ST_WAIT;
                    end
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r == 4'd0) begin
                    access_s     = 1'b1;
                    next_state_s = ST_RESP;
                end else begin
                    cnt_next_s   = cnt_r - 4'd1;
                    next_state_s = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (i_rsp_ready) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_RESP;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
                cnt_next_s   = 4'd0;
            end
        endcase
    end

    // State, counter and registered handshake outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 4'd0;
            ready_r     <= 1'b1;
            rsp_valid_r <= 1'b0;
        end else begin
            state_r     <= next_state_s;
            cnt_r       <= cnt_next_s;
            ready_r     <= (next_state_s == ST_IDLE);
            rsp_valid_r <= (next_state_s == ST_RESP);
        end
    end

    // Request capture on accept; ignored in every other state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cap_we_r    <= 1'b0;
            cap_addr_r  <= {ADDR_W{1'b0}};
            cap_wdata_r <= {DATA_W{1'b0}};
            cap_be_r    <= {BE_W{1'b0}};
        end else if (accept_s) begin
            cap_we_r    <= i_req_we;
            cap_addr_r  <= i_req_addr;
            cap_wdata_r <= i_req_wdata;
            cap_be_r    <= i_req_be;
        end
    end

    // Byte-masked storage write; contents deliberately have no reset.
    always_ff @(posedge i_clk) begin
        if (mem_we_s) begin
            for (int k = 0; k < BE_W; k++) begin
                if (acc_be_s[k]) begin
                    mem_r[acc_idx_s][8*k +: 8] <= acc_wdata_s[8*k +: 8];
                end
            end
        end
    end

    // Response data/error registered at the access edge and held through RESP.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rdata_r <= {DATA_W{1'b0}};
            err_r   <= 1'b0;
        end else if (access_s) begin
            if (!acc_in_range_s) begin
                rdata_r <= {DATA_W{1'b0}};
                err_r   <= 1'b1;
            end else if (acc_we_s) begin
                rdata_r <= {DATA_W{1'b0}};
                err_r   <= 1'b0;
            end else begin
                rdata_r <= mem_r[acc_idx_s];
                err_r   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Testbench for mem_responder: three instances (WAIT_STATES = 1, 0, 15) share
// clock, reset and request data; each has its own valid/ready handshake.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  req_valid;
    logic [2:0]  rsp_ready;
    logic        req_we;
    logic [15:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    wire  [2:0]  req_ready;
    wire  [2:0]  rsp_valid;
    wire  [2:0]  err_a;
    logic [31:0] rdata_a [3];

    int checks = 0;
    int errors = 0;

    // Reference storage for the WAIT_STATES=1 instance, keyed by word address.
    bit [31:0] mdl [int];

    always #5 clk = ~clk;

    mem_responder #(.ADDR_W(16), .DATA_W(32), .DEPTH_LOG2(10), .WAIT_STATES(1)) u_dut_ws1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid[0]), .o_req_ready(req_ready[0]),
        .i_req_we(req_we), .i_req_addr(req_addr), .i_req_wdata(req_wdata), .i_req_be(req_be),
        .o_rsp_valid(rsp_valid[0]), .i_rsp_ready(rsp_ready[0]), .o_rsp_rdata(rdata_a[0]), .o_rsp_err(err_a[0]));

    mem_responder #(.ADDR_W(16), .DATA_W(32), .DEPTH_LOG2(10), .WAIT_STATES(0)) u_dut_ws0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid[1]), .o_req_ready(req_ready[1]),
        .i_req_we(req_we), .i_req_addr(req_addr), .i_req_wdata(req_wdata), .i_req_be(req_be),
        .o_rsp_valid(rsp_valid[1]), .i_rsp_ready(rsp_ready[1]), .o_rsp_rdata(rdata_a[1]), .o_rsp_err(err_a[1]));

    mem_responder #(.ADDR_W(16), .DATA_W(32), .DEPTH_LOG2(10), .WAIT_STATES(15)) u_dut_ws15 (
        .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid[2]), .o_req_ready(req_ready[2]),
        .i_req_we(req_we), .i_req_addr(req_addr), .i_req_wdata(req_wdata), .i_req_be(req_be),
        .o_rsp_valid(rsp_valid[2]), .i_rsp_ready(rsp_ready[2]), .o_rsp_rdata(rdata_a[2]), .o_rsp_err(err_a[2]));

    // Byte-wise merge of new data into an old word.
    function automatic bit [31:0] merge(input bit [31:0] old, input bit [31:0] wd, input bit [3:0] be);
        bit [31:0] r;
        r = old;
        for (int k = 0; k < 4; k++) begin
            if (be[k]) r[8*k +: 8] = wd[8*k +: 8];
        end
        return r;
    endfunction

    // One full transaction on instance d; returns response and latency in edges.
    // During the hold phase the request bus is scrambled and the response must stay put.
    task automatic do_req(input int d, input bit we, input logic [15:0] addr, input logic [31:0] wd,
                          input logic [3:0] be, input int hold,
                          output logic [31:0] rd, output logic er, output int lat);
        int t;
        t = 0;
        while (req_ready[d] !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (req_ready[d] !== 1'b1) begin
            errors++;
            $display("FAIL ready_wait dut%0d: got %b want 1", d, req_ready[d]);
        end
        req_we = we; req_addr = addr; req_wdata = wd; req_be = be;
        req_valid[d] = 1'b1;
        @(posedge clk); #1;
        req_valid[d] = 1'b0;
        lat = 1;
        @(negedge clk);
        while (rsp_valid[d] !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (rsp_valid[d] !== 1'b1) begin
            errors++;
            $display("FAIL rsp_timeout dut%0d: got %b want 1", d, rsp_valid[d]);
        end
        rd = rdata_a[d];
        er = err_a[d];
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            req_valid[d] = 1'($urandom_range(1, 0));
            req_we    = 1'($urandom_range(1, 0));
            req_addr  = 16'($urandom_range(15, 0));
            req_wdata = $urandom;
            req_be    = 4'($urandom);
            @(negedge clk);
            checks++;
            if (rsp_valid[d] !== 1'b1 || req_ready[d] !== 1'b0 || rdata_a[d] !== rd || err_a[d] !== er) begin
                errors++;
                $display("FAIL stall_stable dut%0d: got v=%b r=%b d=%h e=%b want v=1 r=0 d=%h e=%b",
                         d, rsp_valid[d], req_ready[d], rdata_a[d], err_a[d], rd, er);
            end
        end
        req_valid[d] = 1'b0;
        rsp_ready[d] = 1'b1;
        @(posedge clk); #1;
        rsp_ready[d] = 1'b0;
        @(negedge clk);
        checks++;
        if (rsp_valid[d] !== 1'b0 || req_ready[d] !== 1'b1) begin
            errors++;
            $display("FAIL release dut%0d: got v=%b r=%b want v=0 r=1", d, rsp_valid[d], req_ready[d]);
        end
    endtask

    // Outputs while reset is held.
    task automatic test_reset();
        #12;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (rsp_valid[d] !== 1'b0 || rdata_a[d] !== 32'h0 || err_a[d] !== 1'b0 || req_ready[d] !== 1'b1) begin
                errors++;
                $display("FAIL reset_state dut%0d: got v=%b d=%h e=%b r=%b want v=0 d=0 e=0 r=1",
                         d, rsp_valid[d], rdata_a[d], err_a[d], req_ready[d]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Full and partial writes, out-of-range access with no aliasing.
    task automatic test_directed();
        logic [31:0] rd;
        logic        er;
        int          lat;
        do_req(0, 1'b1, 16'h0005, 32'hDEADBEEF, 4'hF, 0, rd, er, lat);
        mdl[5] = 32'hDEADBEEF;
        checks++;
        if (rd !== 32'h0 || er !== 1'b0 || lat !== 2) begin
            errors++;
            $display("FAIL write_full: got d=%h e=%b lat=%0d want d=0 e=0 lat=2", rd, er, lat);
        end
        do_req(0, 1'b0, 16'h0005, 32'h0, 4'h0, 0, rd, er, lat);
        checks++;
        if (rd !== 32'hDEADBEEF || er !== 1'b0 || lat !== 2) begin
            errors++;
            $display("FAIL read_full: got d=%h e=%b lat=%0d want d=deadbeef e=0 lat=2", rd, er, lat);
        end
        do_req(0, 1'b1, 16'h0005, 32'h11223344, 4'h5, 0, rd, er, lat);
        mdl[5] = merge(mdl[5], 32'h11223344, 4'h5);
        do_req(0, 1'b0, 16'h0005, 32'h0, 4'h0, 0, rd, er, lat);
        checks++;
        if (rd !== 32'hDE22BE44 || er !== 1'b0) begin
            errors++;
            $display("FAIL read_partial: got d=%h e=%b want d=de22be44 e=0", rd, er);
        end
        do_req(0, 1'b1, 16'h0000, 32'hA5A50000, 4'hF, 0, rd, er, lat);
        mdl[0] = 32'hA5A50000;
        do_req(0, 1'b0, 16'h0400, 32'h0, 4'h0, 0, rd, er, lat);
        checks++;
        if (rd !== 32'h0 || er !== 1'b1) begin
            errors++;
            $display("FAIL read_oor: got d=%h e=%b want d=0 e=1", rd, er);
        end
        do_req(0, 1'b1, 16'h0400, 32'hFFFFFFFF, 4'hF, 0, rd, er, lat);
        checks++;
        if (rd !== 32'h0 || er !== 1'b1) begin
            errors++;
            $display("FAIL write_oor: got d=%h e=%b want d=0 e=1", rd, er);
        end
        do_req(0, 1'b0, 16'h0000, 32'h0, 4'h0, 0, rd, er, lat);
        checks++;
        if (rd !== 32'hA5A50000 || er !== 1'b0) begin
            errors++;
            $display("FAIL no_alias: got d=%h e=%b want d=a5a50000 e=0", rd, er);
        end
    endtask

    // Response held for five cycles with a noisy request bus.
    task automatic test_stall();
        logic [31:0] rd;
        logic        er;
        int          lat;
        do_req(0, 1'b0, 16'h0005, 32'h0, 4'h0, 5, rd, er, lat);
        checks++;
        if (rd !== 32'hDE22BE44 || er !== 1'b0) begin
            errors++;
            $display("FAIL stall_read: got d=%h e=%b want d=de22be44 e=0", rd, er);
        end
        do_req(0, 1'b0, 16'h0005, 32'h0, 4'h0, 0, rd, er, lat);
        checks++;
        if (rd !== 32'hDE22BE44) begin
            errors++;
            $display("FAIL stall_no_side_effect: got d=%h want d=de22be44", rd);
        end
    endtask

    // Reset asserted while a write waits: outputs clear at once, storage untouched.
    task automatic test_reset_mid_wait();
        logic [31:0] rd;
        logic        er;
        int          lat;
        do_req(0, 1'b1, 16'h0007, 32'hCAFEF00D, 4'hF, 0, rd, er, lat);
        mdl[7] = 32'hCAFEF00D;
        do_req(0, 1'b0, 16'h0005, 32'h0, 4'h0, 0, rd, er, lat);
        req_we = 1'b1; req_addr = 16'h0007; req_wdata = 32'h12345678; req_be = 4'hF;
        req_valid[0] = 1'b1;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (rsp_valid[0] !== 1'b0 || rdata_a[0] !== 32'h0 || err_a[0] !== 1'b0 || req_ready[0] !== 1'b1) begin
            errors++;
            $display("FAIL async_reset: got v=%b d=%h e=%b r=%b want v=0 d=0 e=0 r=1",
                     rsp_valid[0], rdata_a[0], err_a[0], req_ready[0]);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        do_req(0, 1'b0, 16'h0007, 32'h0, 4'h0, 0, rd, er, lat);
        checks++;
        if (rd !== 32'hCAFEF00D || er !== 1'b0 || lat !== 2) begin
            errors++;
            $display("FAIL abandoned_write: got d=%h e=%b lat=%0d want d=cafef00d e=0 lat=2", rd, er, lat);
        end
    endtask

    // Randomised mix of reads/writes, in and out of range, against the model.
    task automatic test_random();
        logic [31:0] rd, wd, exp_rd;
        logic        er, we, exp_err;
        logic [15:0] addr;
        logic [3:0]  be;
        int          lat, hold;
        logic [15:0] far_addrs [4];
        far_addrs[0] = 16'h0400; far_addrs[1] = 16'h07FF; far_addrs[2] = 16'hFFFF; far_addrs[3] = 16'h0410;
        for (int i = 0; i < 16; i++) begin
            wd = $urandom;
            do_req(0, 1'b1, 16'(i), wd, 4'hF, 0, rd, er, lat);
            mdl[i] = wd;
        end
        for (int i = 0; i < 60; i++) begin
            we   = 1'($urandom_range(1, 0));
            addr = ($urandom_range(9, 0) < 7) ? 16'($urandom_range(15, 0)) : far_addrs[$urandom_range(3, 0)];
            wd   = $urandom;
            be   = 4'($urandom);
            hold = $urandom_range(2, 0);
            exp_err = (addr >= 16'h0400);
            exp_rd  = (!we && !exp_err) ? mdl[int'(addr)] : 32'h0;
            do_req(0, we, addr, wd, be, hold, rd, er, lat);
            if (we && !exp_err) mdl[int'(addr)] = merge(mdl[int'(addr)], wd, be);
            checks++;
            if (rd !== exp_rd || er !== exp_err || lat !== 2) begin
                errors++;
                $display("FAIL random_%0d we=%b a=%h: got d=%h e=%b lat=%0d want d=%h e=%b lat=2",
                         i, we, addr, rd, er, lat, exp_rd, exp_err);
            end
        end
    endtask

    // Latency of the zero-wait and maximum-wait builds.
    task automatic test_latency();
        logic [31:0] rd;
        logic        er;
        int          lat;
        do_req(1, 1'b1, 16'h0003, 32'h0BADF00D, 4'hF, 0, rd, er, lat);
        checks++;
        if (lat !== 1 || er !== 1'b0) begin
            errors++;
            $display("FAIL ws0_write: got lat=%0d e=%b want lat=1 e=0", lat, er);
        end
        do_req(1, 1'b0, 16'h0003, 32'h0, 4'h0, 0, rd, er, lat);
        checks++;
        if (lat !== 1 || rd !== 32'h0BADF00D) begin
            errors++;
            $display("FAIL ws0_read: got lat=%0d d=%h want lat=1 d=0badf00d", lat, rd);
        end
        do_req(2, 1'b1, 16'h03FF, 32'h5A5A1234, 4'hF, 0, rd, er, lat);
        checks++;
        if (lat !== 16 || er !== 1'b0) begin
            errors++;
            $display("FAIL ws15_write: got lat=%0d e=%b want lat=16 e=0", lat, er);
        end
        do_req(2, 1'b0, 16'h03FF, 32'h0, 4'h0, 0, rd, er, lat);
        checks++;
        if (lat !== 16 || rd !== 32'h5A5A1234) begin
            errors++;
            $display("FAIL ws15_read: got lat=%0d d=%h want lat=16 d=5a5a1234", lat, rd);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 3'b000;
        rsp_ready = 3'b000;
        req_we = 1'b0;
        req_addr = 16'h0;
        req_wdata = 32'h0;
        req_be = 4'h0;
        test_reset();
        test_directed();
        test_stall();
        test_reset_mid_wait();
        test_random();
        test_latency();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
